// File: rtl/alu_request_arbiter.sv
// rtl/alu_request_arbiter.sv - two-requester round-robin arbiter in front of a shared 8-bit ALU
//
// Purpose:
//   Arbitrates between requester 0 (switch/button front-end) and requester 1
//   (self-test generator), latches the winner's opcode and operands, strobes
//   the ALU, waits ALU_LAT cycles, captures the 16-bit result with
//   zero/negative/carry/overflow flags and pulses done to the winner.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   req[1:0]             per-requester request, held until its done
//   op0/op1, a0/b0/a1/b1 per-requester opcode and operands
//   gnt[1:0]             one-hot grant, ISSUE through RESP
//   done[1:0]            one-cycle completion pulse to the granted requester
//   rsp_result, rsp_*    captured result and flags, held until the next capture
//   alu_a/alu_b/alu_op   latched operands/opcode towards the ALU
//   alu_start            one-cycle issue strobe
//   alu_result           ALU output, sampled at the end of WAIT

module alu_request_arbiter #(
    parameter int ALU_LAT = 1   // legal range 1..15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req,
    input  logic [2:0]  op0,
    input  logic [2:0]  op1,
    input  logic [7:0]  a0,
    input  logic [7:0]  b0,
    input  logic [7:0]  a1,
    input  logic [7:0]  b1,
    output logic [1:0]  gnt,
    output logic [1:0]  done,
    output logic [15:0] rsp_result,
    output logic        rsp_zero,
    output logic        rsp_neg,
    output logic        rsp_carry,
    output logic        rsp_ovf,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [2:0]  alu_op,
    output logic        alu_start,
    input  logic [15:0] alu_result
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(ALU_LAT - 1);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_INC = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_MUL = 3'd3;

    state_t     state;
    state_t     state_nx;
    logic [3:0] wait_cnt;
    logic       rr_pri;     // requester that wins when both request
    logic       winner;
    logic       grant_now;

    // Flag values computed from the latched operands and the live ALU output,
    // registered together with the result at the end of WAIT.
    logic [7:0] res_lo;
    logic       f_zero;
    logic       f_neg;
    logic       f_carry;
    logic       f_ovf;

    // ---------------------------------------------------------------
    // Arbitration
    // ---------------------------------------------------------------
    always_comb begin
        grant_now = (state == S_IDLE) && (req != 2'b00);
        unique case (req)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            default: winner = rr_pri;
        endcase
    end

    // ---------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  if (grant_now) state_nx = S_ISSUE;
            S_ISSUE: state_nx = S_WAIT;
            S_WAIT:  if (wait_cnt == 4'd0) state_nx = S_RESP;
            S_RESP:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Strobes decoded from state so that reset clears them immediately.
    assign alu_start = (state == S_ISSUE);
    assign done      = (state == S_RESP) ? gnt : 2'b00;

    // ---------------------------------------------------------------
    // Flags
    // ---------------------------------------------------------------
    always_comb begin
        res_lo  = alu_result[7:0];
        f_zero  = (alu_result == 16'h0000);
        f_neg   = res_lo[7];
        f_carry = 1'b0;
        f_ovf   = 1'b0;
        unique case (alu_op)
            OP_ADD: begin
                f_carry = alu_result[8];
                f_ovf   = (alu_a[7] == alu_b[7]) && (res_lo[7] != alu_a[7]);
            end
            OP_INC: begin
                f_ovf = (alu_a == 8'h7F);
            end
            OP_SUB: begin
                f_carry = (alu_a < alu_b);
                f_ovf   = (alu_a[7] != alu_b[7]) && (res_lo[7] != alu_a[7]);
            end
            OP_MUL: begin
                f_neg = alu_result[15];
                f_ovf = (alu_result[15:8] != {8{alu_result[7]}});
            end
            default: begin
                f_carry = 1'b0;
                f_ovf   = 1'b0;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Datapath registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt        <= 2'b00;
            rr_pri     <= 1'b0;
            wait_cnt   <= 4'd0;
            alu_a      <= 8'h00;
            alu_b      <= 8'h00;
            alu_op     <= 3'd0;
            rsp_result <= 16'h0000;
            rsp_zero   <= 1'b0;
            rsp_neg    <= 1'b0;
            rsp_carry  <= 1'b0;
            rsp_ovf    <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (grant_now) begin
                        alu_op <= winner ? op1 : op0;
                        alu_a  <= winner ? a1  : a0;
                        alu_b  <= winner ? b1  : b0;
                        gnt    <= winner ? 2'b10 : 2'b01;
                        rr_pri <= ~winner;
                    end
                end
                S_ISSUE: begin
                    wait_cnt <= WAIT_LOAD;
                end
                S_WAIT: begin
                    if (wait_cnt != 4'd0) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end else begin
                        rsp_result <= alu_result;
                        rsp_zero   <= f_zero;
                        rsp_neg    <= f_neg;
                        rsp_carry  <= f_carry;
                        rsp_ovf    <= f_ovf;
                    end
                end
                S_RESP: begin
                    gnt <= 2'b00;
                end
                default: begin
                    gnt <= 2'b00;
                end
            endcase
        end
    end

endmodule
